// File: rtl/divider_pkg.sv
// divider_pkg: shared state encoding and sizing helper for divider_seq
package divider_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_INIT = 3'b001;
  localparam state_t S_COMP = 3'b010;
  localparam state_t S_DONE = 3'b100;
  function automatic int ITER_W(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/divider_step.sv
// divider_step: one restoring-division iteration
//   r_i/q_i/y_i : partial remainder (WIDTH+1), dividend/quotient shift reg, divisor
//   r_o/q_o     : next partial remainder and next shift register
module divider_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH:0]   r_o,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH:0] t;
  logic           ge;
  assign t = {r_i[WIDTH-1:0], q_i[WIDTH-1]};
  // r_i[WIDTH] is always 0 in a restoring divider; folding it in keeps the shifted-out bit meaningful
  assign ge = r_i[WIDTH] | (t >= {1'b0, y_i});
  assign r_o = ge ? t - {1'b0, y_i} : t;
  assign q_o = {q_i[WIDTH-2:0], ge};
endmodule

// File: rtl/divider_seq.sv
// divider_seq: sequential radix-2 restoring divider with Start/Done/Ack handshake and SCEN step enable
//   Clk, Reset (async, active-high), Start, Ack, SCEN, Xin/Yin (dividend/divisor)
//   Quotient/Remainder/DivZero registered results; Done and Qi/Qc/Qd decode the one-hot state
//   DIVIDER_SIGNED_EN: two's-complement operands, truncation toward zero
module divider_seq
  import divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Ack,
  input  logic             SCEN,
  input  logic [WIDTH-1:0] Xin,
  input  logic [WIDTH-1:0] Yin,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Done,
  output logic             DivZero,
  output logic             Qi,
  output logic             Qc,
  output logic             Qd
);
  localparam int IW = ITER_W(WIDTH);
  state_t           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d, rn;
  logic [WIDTH-1:0] q_q, q_d, qn, y_q, y_d, quo_q, quo_d, rem_q, rem_d, xa, ya, quo_n, rem_n;
  logic [IW-1:0]    cnt_q, cnt_d;
  logic             dz_q, dz_d;
  divider_step #(.WIDTH(WIDTH)) u_step (.r_i(r_q), .q_i(q_q), .y_i(y_q), .r_o(rn), .q_o(qn));
`ifdef DIVIDER_SIGNED_EN
  logic sx_q, sq_q;
  assign xa    = Xin[WIDTH-1] ? -Xin : Xin;
  assign ya    = Yin[WIDTH-1] ? -Yin : Yin;
  assign quo_n = sq_q ? -qn : qn;
  assign rem_n = sx_q ? -rn[WIDTH-1:0] : rn[WIDTH-1:0];
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) {sx_q, sq_q} <= 2'b00;
    else if (state_q[0] && Start) {sx_q, sq_q} <= {Xin[WIDTH-1], Xin[WIDTH-1] ^ Yin[WIDTH-1]};
`else
  assign xa    = Xin;
  assign ya    = Yin;
  assign quo_n = qn;
  assign rem_n = rn[WIDTH-1:0];
`endif
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    if (state_q[0] && Start) begin
      q_d     = xa;
      y_d     = ya;
      r_d     = '0;
      cnt_d   = '0;
      dz_d    = Yin == '0;
      state_d = dz_d ? S_DONE : S_COMP;
      quo_d   = dz_d ? '1 : quo_q;
      rem_d   = dz_d ? Xin : rem_q;
    end else if (state_q[1] && SCEN) begin
      r_d   = rn;
      q_d   = qn;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == IW'(WIDTH - 1)) begin
        state_d = S_DONE;
        quo_d   = quo_n;
        rem_d   = rem_n;
      end
    end else if (state_q[2] && Ack) begin
      state_d = S_INIT;
    end
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state_q <= S_INIT;
      r_q     <= '0;
      q_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  assign {Qd, Qc, Qi} = state_q;
  assign Done         = state_q[2];
  assign Quotient     = quo_q;
  assign Remainder    = rem_q;
  assign DivZero      = dz_q;
endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: randomized and directed self-checking bench for divider_seq
module tb_divider_seq;
  localparam int W = 8;
  logic         Clk = 1'b0;
  logic         Reset, Start, Ack, SCEN;
  logic [W-1:0] Xin, Yin, Quotient, Remainder;
  logic         Done, DivZero, Qi, Qc, Qd;
  int checks = 0;
  int errors = 0;
  always #5 Clk = ~Clk;
  divider_seq #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .SCEN(SCEN),
    .Xin(Xin), .Yin(Yin), .Quotient(Quotient), .Remainder(Remainder),
    .Done(Done), .DivZero(DivZero), .Qi(Qi), .Qc(Qc), .Qd(Qd)
  );
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    int xs, ys;
    if (y == '0) begin
      q = '1; r = x; dz = 1'b1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      xs = $signed(x); ys = $signed(y);
`else
      xs = int'(x); ys = int'(y);
`endif
      q = W'(xs / ys); r = W'(xs % ys); dz = 1'b0;
    end
  endfunction
  // mode 0: SCEN held high, 1: toggled every cycle, 2: random
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input int mode,
                        output int n, output int exp_n);
    int dis = 0;
    Xin = x; Yin = y; Start = 1'b1; SCEN = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0; n = 1;
    while (!Done && n < 200) begin
      if (mode == 1) SCEN = ~SCEN;
      else if (mode == 2) SCEN = 1'($urandom_range(0, 1));
      if (Qc && !SCEN) dis++;
      @(posedge Clk); #1;
      n++;
    end
    SCEN = 1'b1;
    exp_n = (y == '0) ? 1 : W + 1 + dis;
  endtask
  task automatic ack;
    Ack = 1'b1;
    @(posedge Clk); #1;
    Ack = 1'b0;
  endtask
  task automatic test_reset;
    Reset = 1'b1; Start = 1'b0; Ack = 1'b0; SCEN = 1'b1; Xin = '0; Yin = '0;
    @(posedge Clk); #1;
    checks++;
    if ({Qd, Qc, Qi, Done, DivZero, Quotient, Remainder} !== {3'b001, 2'b00, 16'h0000}) begin
      errors++;
      $display("FAIL reset_state got %b required %b", {Qd, Qc, Qi, Done, DivZero, Quotient, Remainder}, {3'b001, 2'b00, 16'h0000});
    end
    Reset = 1'b0;
  endtask
  task automatic test_vectors;
`ifdef DIVIDER_SIGNED_EN
    int tv[3][4] = '{'{-7, 2, -3, -1}, '{7, -2, -3, 1}, '{-128, -1, -128, 0}};
`else
    int tv[4][4] = '{'{200, 7, 28, 4}, '{5, 9, 0, 5}, '{255, 1, 255, 0}, '{100, 10, 10, 0}};
`endif
    int n, en;
    logic [W-1:0] eq, er;
    foreach (tv[i]) begin
      eq = W'(tv[i][2]); er = W'(tv[i][3]);
      run_op(W'(tv[i][0]), W'(tv[i][1]), 0, n, en);
      checks++;
      if (n !== W + 1) begin errors++; $display("FAIL vec%0d_latency got %0d required %0d", i, n, W + 1); end
      checks++;
      if ({Quotient, Remainder, DivZero} !== {eq, er, 1'b0}) begin
        errors++;
        $display("FAIL vec%0d_result got q=%0d r=%0d dz=%b required q=%0d r=%0d dz=0", i, Quotient, Remainder, DivZero, eq, er);
      end
      Start = 1'b1; Xin = 8'h33; Yin = 8'h05;
      @(posedge Clk); #1;
      Start = 1'b0;
      checks++;
      if ({Done, Qd, Quotient, Remainder} !== {2'b11, eq, er}) begin
        errors++;
        $display("FAIL vec%0d_hold got done=%b q=%0d r=%0d required done=1 q=%0d r=%0d", i, Done, Quotient, Remainder, eq, er);
      end
      ack;
      checks++;
      if ({Qi, Done} !== 2'b10) begin errors++; $display("FAIL vec%0d_ack got qi=%b done=%b required qi=1 done=0", i, Qi, Done); end
    end
  endtask
  task automatic test_divzero;
    int n, en;
    run_op(8'd77, 8'd0, 0, n, en);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL divzero_latency got %0d required 1", n); end
    checks++;
    if ({Quotient, Remainder, DivZero} !== {8'hFF, 8'd77, 1'b1}) begin
      errors++;
      $display("FAIL divzero_result got q=%h r=%0d dz=%b required q=ff r=77 dz=1", Quotient, Remainder, DivZero);
    end
    ack;
    checks++;
    if ({Qd, Qc, Qi} !== 3'b001) begin errors++; $display("FAIL divzero_ack got %b required 001", {Qd, Qc, Qi}); end
  endtask
  task automatic test_scen_toggle;
    int n, en;
    logic [W-1:0] eq, er;
    logic edz;
    model(8'd200, 8'd7, eq, er, edz);
    run_op(8'd200, 8'd7, 1, n, en);
    checks++;
    if (n !== en || n <= W + 1) begin errors++; $display("FAIL scen_latency got %0d required %0d", n, en); end
    checks++;
    if ({Quotient, Remainder, DivZero} !== {eq, er, edz}) begin
      errors++;
      $display("FAIL scen_result got q=%0d r=%0d required q=%0d r=%0d", Quotient, Remainder, eq, er);
    end
    ack;
  endtask
  task automatic test_reset_mid;
    int n, en;
    logic [W-1:0] eq, er;
    logic edz;
    Xin = 8'd200; Yin = 8'd7; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    #1;
    checks++;
    if ({Qd, Qc, Qi, Done, DivZero, Quotient, Remainder} !== {3'b001, 2'b00, 16'h0000}) begin
      errors++;
      $display("FAIL reset_mid got %b required %b", {Qd, Qc, Qi, Done, DivZero, Quotient, Remainder}, {3'b001, 2'b00, 16'h0000});
    end
    Reset = 1'b0;
    @(posedge Clk); #1;
    model(8'd100, 8'd10, eq, er, edz);
    run_op(8'd100, 8'd10, 0, n, en);
    checks++;
    if ({Quotient, Remainder, DivZero} !== {eq, er, edz} || n !== en) begin
      errors++;
      $display("FAIL reset_mid_op got q=%0d r=%0d lat=%0d required q=%0d r=%0d lat=%0d", Quotient, Remainder, n, eq, er, en);
    end
    ack;
  endtask
  task automatic test_back_to_back;
    int n = 0;
    logic [W-1:0] eq, er;
    logic edz;
    Xin = 8'd200; Yin = 8'd7; Start = 1'b1;
    @(posedge Clk); #1;
    while (!Done && n < 100) begin @(posedge Clk); #1; n++; end
    Xin = 8'd255; Yin = 8'd1; Ack = 1'b1;
    @(posedge Clk); #1;
    Ack = 1'b0;
    checks++;
    if ({Qd, Qc, Qi} !== 3'b001) begin errors++; $display("FAIL b2b_leave got %b required 001", {Qd, Qc, Qi}); end
    @(posedge Clk); #1;
    Start = 1'b0;
    checks++;
    if ({Qd, Qc, Qi} !== 3'b010) begin errors++; $display("FAIL b2b_restart got %b required 010", {Qd, Qc, Qi}); end
    n = 1;
    while (!Done && n < 100) begin @(posedge Clk); #1; n++; end
    model(8'd255, 8'd1, eq, er, edz);
    checks++;
    if ({Quotient, Remainder, DivZero} !== {eq, er, edz} || n !== W + 1) begin
      errors++;
      $display("FAIL b2b_result got q=%0d r=%0d lat=%0d required q=%0d r=%0d lat=%0d", Quotient, Remainder, n, eq, er, W + 1);
    end
    ack;
  endtask
  task automatic test_random;
    int n, en;
    logic [W-1:0] x, y, eq, er;
    logic edz;
    for (int k = 0; k < 60; k++) begin
      x = W'($urandom);
      y = (k % 10 == 3) ? '0 : W'($urandom);
      model(x, y, eq, er, edz);
      run_op(x, y, k % 3, n, en);
      checks++;
      if ({Quotient, Remainder, DivZero} !== {eq, er, edz} || n !== en) begin
        errors++;
        $display("FAIL rand%0d %0d/%0d got q=%0d r=%0d dz=%b lat=%0d required q=%0d r=%0d dz=%b lat=%0d",
                 k, x, y, Quotient, Remainder, DivZero, n, eq, er, edz, en);
      end
      ack;
    end
  endtask
  initial begin
    test_reset;
    test_vectors;
    test_divzero;
    test_scen_toggle;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/divider_seq.md
# divider_seq

Parametrised sequential radix-2 restoring divider with Start/Done/Ack handshake and SCEN single-step enable. It is the next generation of the team's fixed 8-bit repeated-subtraction divider: operand width is set by `WIDTH`, latency is a fixed `WIDTH` enabled cycles whatever the operand values, and divide-by-zero is flagged. It sits on the datapath as a multi-cycle arithmetic unit under control of a host FSM or a manual single-step board harness.

## Interface
- `WIDTH`, default 8, operand and result width in bits (2..32).
- `Clk`  in  1  clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high.
- `Start`  in  1  begin division; sampled only in INITIAL.
- `Ack`  in  1  host acknowledges the result; sampled only in DONE_S.
- `SCEN`  in  1  step enable; gates COMPUTE iterations only.
- `Xin`  in  WIDTH  dividend.
- `Yin`  in  WIDTH  divisor.
- `Quotient`  out  WIDTH  registered result quotient.
- `Remainder`  out  WIDTH  registered result remainder.
- `Done`  out  1  high exactly while in DONE_S.
- `DivZero`  out  1  registered; the last operation had `Yin` equal to 0.
- `Qi`, `Qc`, `Qd`  out  1 each  one-hot state bits for INITIAL, COMPUTE and DONE_S.

## Operation
- States are one-hot: INITIAL=3'b001, COMPUTE=3'b010, DONE_S=3'b100. `{Qd,Qc,Qi}` equals the state register.
- **INITIAL:** on an edge with `Start`=1, capture `Xin` into the shift register Q and `Yin` into Y. Clear the partial remainder R (WIDTH+1 bits) and the iteration counter (`$clog2(WIDTH+1)` bits).
  - If `Yin`==0: go directly to DONE_S. Set `Quotient`=all ones, `Remainder`=`Xin`, `DivZero`=1.
  - Otherwise: go to COMPUTE and set `DivZero`=0.
- **COMPUTE:** each edge with `SCEN`=1 performs one iteration:
  - t = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - If t ≥ {1'b0,Y}: R = t−Y, shift 1 into Q. Otherwise: R = t, shift 0 into Q.
  - Increment the counter.
  - On the iteration that brings the counter to WIDTH, load `Quotient`=Q' and `Remainder`=R'[WIDTH-1:0], and go to DONE_S.
  - An edge with `SCEN`=0 leaves all state unchanged.
- **DONE_S:** results hold. `Ack`=1 moves the block to INITIAL on the next edge. `Quotient`, `Remainder` and `DivZero` keep their values until the next load.
- `Start` outside INITIAL and `Ack` outside DONE_S are ignored.
- Invariant on every non-zero-divisor result: `Quotient`·`Yin` + `Remainder` = `Xin` and `Remainder` < `Yin`.

## Timing
- Reset values: state INITIAL (`Qi`=1, `Qc`=0, `Qd`=0), `Done`=0, `Quotient`=0, `Remainder`=0, `DivZero`=0. Internal Q, R, Y and the counter are 0.
- Latency with `SCEN` held at 1:
  - The Start edge enters COMPUTE.
  - `Done` rises WIDTH edges later (WIDTH+1 edges after Start is sampled).
  - A divide-by-zero raises `Done` one edge after Start.
- Each `SCEN`=0 cycle in COMPUTE adds exactly one cycle of latency.
- `Start` held high through DONE_S and Ack: a new operation starts on the first INITIAL edge, one cycle after leaving DONE_S.
- `Reset` asserted mid-COMPUTE or mid-DONE_S aborts immediately to reset values. No partial result is exposed.
- `Done` and the state bits are pure functions of the state register and are glitch-free.

## Configuration
- `DIVIDER_SIGNED_EN` defined: operands are two's complement.
  - At load, Q=|Xin| and Y=|Yin|. The sign of `Xin` and the sign of `Xin`^`Yin` are stored.
  - At the DONE_S transition, the quotient is negated if the signs differ, and the remainder takes the sign of the dividend (truncation toward zero).
  - −2^(WIDTH−1) / −1 gives `Quotient`=−2^(WIDTH−1) (wrap) and `Remainder`=0.
  - Divide-by-zero output is unchanged from the unsigned case.
- Not defined: unsigned only. No sign logic is synthesised.

## Structure
- Package `divider_pkg`:
  - state localparams / `state_t` (one-hot encoding above).
  - `ITER_W(width)` helper for the counter width.
- Sub-module `divider_step` (combinational, parameter `WIDTH`): takes R, Q and Y; returns next R and next Q. It is instantiated once in the top-level FSM/datapath.

## Test plan
- WIDTH=8, Xin=200, Yin=7, SCEN=1: `Done` is high at edge 9 after Start, with Quotient=28, Remainder=4, DivZero=0.
- Xin=5, Yin=9: Quotient=0, Remainder=5. Xin=255, Yin=1: Quotient=255, Remainder=0. Latency is 9 edges in both cases.
- Yin=0, Xin=77: `Done` is high one edge after Start, with Quotient=8'hFF, Remainder=77, DivZero=1. Ack then returns the block to INITIAL (`Qi`=1).
- Toggle SCEN 1,0,1,0… during 200/7: latency is 8 enabled edges plus the number of disabled edges, and the results match the first case.
- Reset pulse at the 4th COMPUTE edge: all outputs return to reset values immediately. A following Start with 100/10 gives Quotient=10, Remainder=0.
- With `DIVIDER_SIGNED_EN`:
  - −7/2 gives −3 remainder −1.
  - 7/−2 gives −3 remainder 1.
  - −128/−1 gives −128 remainder 0.
